// File: rtl/itch_msg_sequencer_if.sv
// Feed-channel bundle between the ITCH word sources and the sequencer.
// A word moves on a cycle where i_ch_valid[c] and o_ch_ready[c] are both high.
// The source holds its valid, last and data stable until that cycle.
interface itch_msg_sequencer_if #(
  parameter int REG_WIDTH = 32,
  parameter int NUM_CH    = 2
) ();
  logic [NUM_CH-1:0]           i_ch_valid;
  logic [NUM_CH-1:0]           i_ch_last;
  logic [NUM_CH*REG_WIDTH-1:0] i_ch_data;
  logic [NUM_CH-1:0]           o_ch_ready;

  modport master (output i_ch_valid, output i_ch_last, output i_ch_data, input o_ch_ready);
  modport slave  (input i_ch_valid, input i_ch_last, input i_ch_data, output o_ch_ready);
endinterface

// File: rtl/itch_msg_sequencer.sv
// Round-robin sequencer that loads 7-word ITCH add-order messages from the feed
// channels into the parser register bank, rejecting short, long and stalled messages.
module itch_msg_sequencer #(
  parameter int REG_WIDTH = 32,
  parameter int NUM_CH    = 2,
  parameter int NUM_WORDS = 7,
  parameter int TIMEOUT   = 64,
  localparam int GW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  itch_msg_sequencer_if.slave  ch,
  output logic [REG_WIDTH-1:0] o_reg_1,
  output logic [REG_WIDTH-1:0] o_reg_2,
  output logic [REG_WIDTH-1:0] o_reg_3,
  output logic [REG_WIDTH-1:0] o_reg_4,
  output logic [REG_WIDTH-1:0] o_reg_5,
  output logic [REG_WIDTH-1:0] o_reg_6,
  output logic [REG_WIDTH-1:0] o_reg_7,
  output logic                 o_load_done,
  output logic                 o_parsed_valid,
  output logic [GW-1:0]        o_grant_ch,
  output logic                 o_busy,
  output logic                 o_err,
  output logic [1:0]           o_dbg_state
);
  localparam int CW = $clog2(NUM_WORDS);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_COMMIT} state_t;

  state_t               r_state, w_state_n;
  logic [GW-1:0]        r_grant, w_grant_n;
  logic [GW-1:0]        r_ptr, w_ptr_n;
  logic [CW-1:0]        r_cnt, w_cnt_n;
  logic [TW-1:0]        r_tmo, w_tmo_n;
  logic                 r_err, w_err_n;
  logic                 r_pv;
  logic                 w_wr;
  logic [REG_WIDTH-1:0] r_bank [NUM_WORDS];

  logic                 w_accepting;
  logic [NUM_CH-1:0]    w_ready;
  logic                 w_valid_g, w_last_g, w_xfer;
  logic [REG_WIDTH-1:0] w_data_g;
  logic                 w_found;
  logic [GW-1:0]        w_pick;

  // Ready is a pure decode of registered state so it never depends on valid.
  assign w_accepting = (r_state == S_LOAD) || (r_state == S_DRAIN);

  always_comb begin
    w_ready   = '0;
    w_valid_g = 1'b0;
    w_last_g  = 1'b0;
    w_data_g  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_grant == GW'(c)) begin
        w_ready[c] = w_accepting;
        w_valid_g  = ch.i_ch_valid[c];
        w_last_g   = ch.i_ch_last[c];
        w_data_g   = ch.i_ch_data[c*REG_WIDTH +: REG_WIDTH];
      end
    end
  end

  assign w_xfer = w_accepting & w_valid_g;

  // First valid channel strictly after the pointer, wrapping back to the pointer itself.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!w_found && ch.i_ch_valid[c] && (((int'(r_ptr) + i) % NUM_CH) == c)) begin
          w_found = 1'b1;
          w_pick  = GW'(c);
        end
      end
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_grant_n = r_grant;
    w_ptr_n   = r_ptr;
    w_cnt_n   = r_cnt;
    w_tmo_n   = r_tmo;
    w_err_n   = 1'b0;
    w_wr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_n = w_pick;
          w_ptr_n   = w_pick;
          w_cnt_n   = '0;
          w_tmo_n   = '0;
          w_state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_xfer) begin
          w_wr    = 1'b1;
          w_cnt_n = r_cnt + 1'b1;
          w_tmo_n = '0;
          if (w_last_g) begin
            if (r_cnt == CW'(NUM_WORDS - 1)) begin
              w_state_n = S_COMMIT;
            end else begin
              w_err_n   = 1'b1;
              w_state_n = S_IDLE;
            end
          end else if (r_cnt == CW'(NUM_WORDS - 1)) begin
            w_err_n   = 1'b1;
            w_state_n = S_DRAIN;
          end
        end else if (r_tmo == TW'(TIMEOUT - 1)) begin
          w_err_n   = 1'b1;
          w_state_n = S_IDLE;
        end else begin
          w_tmo_n = r_tmo + 1'b1;
        end
      end
      S_DRAIN: begin
        if (w_xfer && w_last_g) w_state_n = S_IDLE;
      end
      S_COMMIT: begin
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ptr   <= GW'(NUM_CH - 1);
      r_cnt   <= '0;
      r_tmo   <= '0;
      r_err   <= 1'b0;
      r_pv    <= 1'b0;
      for (int k = 0; k < NUM_WORDS; k++) r_bank[k] <= '0;
    end else begin
      r_state <= w_state_n;
      r_grant <= w_grant_n;
      r_ptr   <= w_ptr_n;
      r_cnt   <= w_cnt_n;
      r_tmo   <= w_tmo_n;
      r_err   <= w_err_n;
      r_pv    <= (r_state == S_COMMIT);
      if (w_wr) r_bank[r_cnt] <= w_data_g;
    end
  end

  assign ch.o_ch_ready    = w_ready;
  assign o_reg_1          = r_bank[0];
  assign o_reg_2          = r_bank[1];
  assign o_reg_3          = r_bank[2];
  assign o_reg_4          = r_bank[3];
  assign o_reg_5          = r_bank[4];
  assign o_reg_6          = r_bank[5];
  assign o_reg_7          = r_bank[6];
  assign o_load_done      = (r_state == S_COMMIT);
  assign o_parsed_valid   = r_pv;
  assign o_grant_ch       = r_grant;
  assign o_busy           = (r_state != S_IDLE);
  assign o_err            = r_err;
  assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_itch_msg_sequencer.sv
// Directed bench for itch_msg_sequencer: good messages, round-robin, short, long,
// stalled and reset-interrupted messages, with hand-derived expected values.
module tb_itch_msg_sequencer;
  localparam int RW = 32;
  localparam int NC = 2;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic [NC-1:0]    tb_valid = '0;
  logic [NC-1:0]    tb_last  = '0;
  logic [NC*RW-1:0] tb_data  = '0;

  logic [RW-1:0] o_reg_1, o_reg_2, o_reg_3, o_reg_4, o_reg_5, o_reg_6, o_reg_7;
  logic          o_load_done, o_parsed_valid, o_busy, o_err;
  logic [0:0]    o_grant_ch;
  logic [1:0]    o_dbg_state;

  itch_msg_sequencer_if #(.REG_WIDTH(RW), .NUM_CH(NC)) ch_if ();
  assign ch_if.i_ch_valid = tb_valid;
  assign ch_if.i_ch_last  = tb_last;
  assign ch_if.i_ch_data  = tb_data;

  itch_msg_sequencer #(.REG_WIDTH(RW), .NUM_CH(NC), .NUM_WORDS(7), .TIMEOUT(64)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .ch(ch_if.slave),
    .o_reg_1(o_reg_1), .o_reg_2(o_reg_2), .o_reg_3(o_reg_3), .o_reg_4(o_reg_4),
    .o_reg_5(o_reg_5), .o_reg_6(o_reg_6), .o_reg_7(o_reg_7),
    .o_load_done(o_load_done), .o_parsed_valid(o_parsed_valid), .o_grant_ch(o_grant_ch),
    .o_busy(o_busy), .o_err(o_err), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int done_cyc_q[$];
  logic [0:0] exp_q[$];
  logic prev_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [RW-1:0] wv(input logic [0:0] c, input int m, input int k);
    return {4'hC, 4'(c), 8'(m), 16'(k)};
  endfunction

  task automatic do_reset(input int n);
    @(negedge i_clk);
    i_rst = 1'b1;
    tb_valid = '0;
    tb_last = '0;
    repeat (n) @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  // driver: present one word, return at the negedge before the edge that accepts it
  task automatic send_word(input logic [0:0] c, input logic [RW-1:0] d, input logic l);
    int budget;
    @(negedge i_clk);
    tb_valid[c] = 1'b1;
    tb_last[c] = l;
    tb_data[c*RW +: RW] = d;
    budget = 0;
    while (!ch_if.o_ch_ready[c] && budget < 300) begin
      @(negedge i_clk);
      budget++;
    end
    if (budget >= 300) check("ready_wait", 64'(budget), 64'(0));
  endtask

  task automatic send_msg(input logic [0:0] c, input int m, input int nwords, input int last_idx);
    for (int k = 0; k < nwords; k++) send_word(c, wv(c, m, k), k == last_idx);
  endtask

  task automatic drop(input logic [0:0] c);
    tb_valid[c] = 1'b0;
    tb_last[c] = 1'b0;
  endtask

  // scoreboard: grant at each done, mutual exclusion of pulses, parsed_valid after done
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_load_done || o_err || o_parsed_valid)
        check("pulse_excl", 64'(int'(o_load_done) + int'(o_err) + int'(o_parsed_valid)), 64'(1));
      if (o_load_done) begin
        done_cnt++;
        done_cyc_q.push_back(cyc);
        if (exp_q.size() > 0) check("done_grant", 64'(o_grant_ch), 64'(exp_q.pop_front()));
        else check("unexpected_done", 64'(1), 64'(0));
      end
      if (o_err) err_cnt++;
      if (o_parsed_valid) check("pv_follows_done", 64'(prev_done), 64'(1));
    end
    prev_done = o_load_done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0;
    do_reset(3);
    // reset state
    check("rst_reg1", 64'(o_reg_1), 64'(0));
    check("rst_reg7", 64'(o_reg_7), 64'(0));
    check("rst_ready", 64'(ch_if.o_ch_ready), 64'(0));
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_done", 64'(o_load_done), 64'(0));
    check("rst_pv", 64'(o_parsed_valid), 64'(0));
    check("rst_err", 64'(o_err), 64'(0));
    check("rst_grant", 64'(o_grant_ch), 64'(0));

    // 1) single good message on ch0
    exp_q.push_back(1'b0);
    send_msg(1'b0, 1, 7, 6);
    @(negedge i_clk);
    drop(1'b0);
    check("t1_done", 64'(o_load_done), 64'(1));
    check("t1_err", 64'(o_err), 64'(0));
    check("t1_reg1", 64'(o_reg_1), 64'(wv(1'b0, 1, 0)));
    check("t1_reg4", 64'(o_reg_4), 64'(wv(1'b0, 1, 3)));
    check("t1_reg7", 64'(o_reg_7), 64'(wv(1'b0, 1, 6)));
    @(negedge i_clk);
    check("t1_pv", 64'(o_parsed_valid), 64'(1));
    check("t1_done_off", 64'(o_load_done), 64'(0));

    // 2) both channels continuously valid: 0,1,0,1 at 9-cycle spacing
    do_reset(2);
    done_cyc_q.delete();
    d0 = done_cnt;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    fork
      begin send_msg(1'b0, 2, 7, 6); send_msg(1'b0, 3, 7, 6); @(negedge i_clk); drop(1'b0); end
      begin send_msg(1'b1, 2, 7, 6); send_msg(1'b1, 3, 7, 6); @(negedge i_clk); drop(1'b1); end
    join
    repeat (2) @(negedge i_clk);
    check("t2_done_count", 64'(done_cnt - d0), 64'(4));
    for (int i = 1; i < done_cyc_q.size(); i++)
      check("t2_period", 64'(done_cyc_q[i] - done_cyc_q[i-1]), 64'(9));
    check("t2_reg1", 64'(o_reg_1), 64'(wv(1'b1, 3, 0)));
    check("t2_reg7", 64'(o_reg_7), 64'(wv(1'b1, 3, 6)));

    // 3) ch1 short message (last on word 4), then a good one
    d0 = done_cnt; e0 = err_cnt;
    send_msg(1'b1, 4, 5, 4);
    @(negedge i_clk);
    drop(1'b1);
    check("t3_err", 64'(o_err), 64'(1));
    check("t3_idle", 64'(o_dbg_state), 64'(0));
    check("t3_reg5", 64'(o_reg_5), 64'(wv(1'b1, 4, 4)));
    check("t3_reg6_kept", 64'(o_reg_6), 64'(wv(1'b1, 3, 5)));
    @(negedge i_clk);
    check("t3_err_pulse", 64'(o_err), 64'(0));
    check("t3_no_done", 64'(done_cnt - d0), 64'(0));
    exp_q.push_back(1'b1);
    send_msg(1'b1, 5, 7, 6);
    @(negedge i_clk);
    drop(1'b1);
    check("t3_done", 64'(o_load_done), 64'(1));
    check("t3_reg7", 64'(o_reg_7), 64'(wv(1'b1, 5, 6)));
    check("t3_err_count", 64'(err_cnt - e0), 64'(1));

    // 4) ch0 nine words, last on word 8: error on word 6, words 7-8 drained
    repeat (2) @(negedge i_clk);
    d0 = done_cnt; e0 = err_cnt;
    send_msg(1'b0, 6, 9, 8);
    @(negedge i_clk);
    drop(1'b0);
    check("t4_idle", 64'(o_busy), 64'(0));
    check("t4_ready", 64'(ch_if.o_ch_ready), 64'(0));
    check("t4_err_count", 64'(err_cnt - e0), 64'(1));
    check("t4_no_done", 64'(done_cnt - d0), 64'(0));
    check("t4_reg1", 64'(o_reg_1), 64'(wv(1'b0, 6, 0)));
    check("t4_reg7", 64'(o_reg_7), 64'(wv(1'b0, 6, 6)));

    // 5) ch0 three words then a 64-cycle stall
    repeat (2) @(negedge i_clk);
    e0 = err_cnt;
    send_msg(1'b0, 7, 3, 99);
    @(negedge i_clk);
    drop(1'b0);
    check("t5_ready_stall1", 64'(ch_if.o_ch_ready), 64'(1));
    repeat (63) @(negedge i_clk);
    check("t5_no_err_yet", 64'(o_err), 64'(0));
    check("t5_busy_stall64", 64'(o_busy), 64'(1));
    @(negedge i_clk);
    check("t5_err", 64'(o_err), 64'(1));
    check("t5_idle", 64'(o_busy), 64'(0));
    check("t5_ready_drop", 64'(ch_if.o_ch_ready), 64'(0));
    check("t5_reg3", 64'(o_reg_3), 64'(wv(1'b0, 7, 2)));

    // 6) reset after 4 words, then a fresh message
    repeat (2) @(negedge i_clk);
    send_msg(1'b0, 8, 4, 99);
    @(negedge i_clk);
    drop(1'b0);
    check("t6_reg4_loaded", 64'(o_reg_4), 64'(wv(1'b0, 8, 3)));
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check("t6_reg1_zero", 64'(o_reg_1), 64'(0));
    check("t6_reg4_zero", 64'(o_reg_4), 64'(0));
    check("t6_busy", 64'(o_busy), 64'(0));
    check("t6_ready", 64'(ch_if.o_ch_ready), 64'(0));
    check("t6_err", 64'(o_err), 64'(0));
    exp_q.push_back(1'b0);
    send_msg(1'b0, 9, 7, 6);
    @(negedge i_clk);
    drop(1'b0);
    check("t6_done", 64'(o_load_done), 64'(1));
    @(negedge i_clk);
    check("t6_pv", 64'(o_parsed_valid), 64'(1));
    check("t6_price", 64'(o_reg_7), 64'(wv(1'b0, 9, 6)));
    check("t6_reg1", 64'(o_reg_1), 64'(wv(1'b0, 9, 0)));

    repeat (3) @(negedge i_clk);
    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    check("total_done", 64'(done_cnt), 64'(7));
    check("total_err", 64'(err_cnt), 64'(3));
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
